cga_vram_arbiter: RTL
=====================

# cga_vram_arbiter

Shares the single 8-bit VRAM between the ISA memory port and the display fetch, using the phase outputs of `cga_sequencer`. On sequencer display-read phases it drives the CRTC-derived address and latches character and attribute bytes for the display pipeline. Inside the ISA window it runs a fixed 3-cycle CPU access and stalls the bus through a ready line until that access is done. It sits directly downstream of `cga_sequencer` and upstream of the character ROM and pixel pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, default 14. VRAM byte-address width.

Ports:
- `clk`  in  1  master clock, same clock as `cga_sequencer`
- `reset_n`  in  1  asynchronous, active-low reset
- `clk_seq`  in  5  sequencer phase, 0..31
- `vram_read`, `vram_read_a0`, `vram_read_char`, `vram_read_att`, `isa_op_enable`, `hres_mode`  in  1 each  sequencer controls
- `disp_addr`  in  ADDR_WIDTH-1  CRTC word address
- `bus_a`  in  ADDR_WIDTH  ISA byte address, already decoded and synchronized
- `bus_memr`, `bus_memw`  in  1 each  level requests, active high
- `bus_din`  in  8  write data
- `bus_dout`  out  8  read data; holds the last read
- `bus_rdy`  out  1  low = insert wait states
- `ram_a`  out  ADDR_WIDTH  SRAM address
- `ram_d`  in  8  SRAM read data (asynchronous SRAM)
- `ram_q`  out  8  SRAM write data
- `ram_ce_l`, `ram_oe_l`, `ram_we_l`  out  1 each  SRAM strobes, active low
- `char_byte`, `att_byte`  out  8 each  latched display bytes

## Operation
- ISA FSM states and transitions:
  - IDLE → WAIT when exactly one of `bus_memr` / `bus_memw` is high.
  - WAIT → SETUP on an edge where `isa_op_enable && clk_seq[3:0] != 4'd14`.
  - SETUP → STROBE → HOLD → DONE, one cycle each.
  - DONE → IDLE when both requests are low.
- Both requests high: ignored. FSM stays in IDLE and `bus_rdy` stays high.
- Address and data capture: `bus_a` and `bus_din` are captured on entry to SETUP. They drive `ram_a` and `ram_q` through SETUP, STROBE and HOLD.
- `ram_ce_l` is low in SETUP, STROBE and HOLD.
- STROBE: `ram_we_l` is low for a write; `ram_oe_l` is low for a read.
- Read capture: `bus_dout` takes `ram_d` at the end of STROBE for reads.
- `bus_rdy` is combinational: `!((bus_memr ^ bus_memw) && state != DONE)`.
- Display side: when `vram_read`, drive `ram_a = {disp_addr, vram_read_a0}` with `ram_ce_l` and `ram_oe_l` low.
  - `char_byte` takes `ram_d` at the end of a `vram_read_char` cycle.
  - `att_byte` takes `ram_d` at the end of a `vram_read_att` cycle.
- No contention by construction: the start gate places HOLD at phase 16 or 0 at the latest, so the ISA access cannot overlap display reads at phases 1–3 and 17–19.
- Simulation assertion: flag any cycle where `vram_read` and a SETUP, STROBE or HOLD state coincide.
- Idle outputs: when neither side is active, `ram_a` holds its last value and all strobes are high.

## Timing
- Reset values:
  - State IDLE; `bus_rdy` 1.
  - `bus_dout`, `char_byte`, `att_byte`, `ram_q` all 0; `ram_a` 0.
  - All strobes 1.
- Reset asserted mid-access: strobes go high immediately (asynchronously) and the FSM returns to IDLE.
- ISA latency:
  - Request sampled with the start gate true at phase k gives SETUP at k+1, STROBE at k+2, HOLD at k+3, DONE at k+4.
  - `bus_rdy` rises combinationally in DONE.
  - Worst case: a request arriving at phase 14 starts at phase 21 and reaches DONE at phase 25.
- Display latency: `char_byte` is valid from phase 3 and phase 19 in hres mode; `att_byte` from phase 4 and phase 20.
- Back-to-back requests: DONE must see both requests low before a new access starts. At most one access per request assertion.

## Configuration
- `CGA_SNOW_EN` defined:
  - A sticky snow flag sets when HOLD completes while `hres_mode` is high.
  - The next `vram_read_char` latch loads the access byte instead of `ram_d` (write data for a write, read data for a read), then the flag clears.
- Undefined: no flag; `char_byte` always comes from `ram_d`.

## Structure
- Shared package `cga_pkg` holds:
  - the FSM state enum (IDLE, WAIT, SETUP, STROBE, HOLD, DONE);
  - `ISA_START_BLOCK = 4'd14`.
- One sub-module, `cga_isa_port`: FSM, address/data capture, `bus_rdy`, `bus_dout`. The top level holds the display latches, SRAM muxing and the snow logic.

## Test plan
- Reset in mid-STROBE of a write: `ram_we_l` goes to 1 the same cycle; after release the state is IDLE and `bus_rdy` is 1.
- Write 0xA5 to 0x0123, request at phase 5:
  - SETUP at 6, `ram_we_l` low only at 7 with `ram_a` 0x0123 and `ram_q` 0xA5;
  - `bus_rdy` is high from phase 9 until the request drops.
- Read at 0x0123 requested at phase 14 returns 0xA5 in `bus_dout`; the access starts at phase 22, and `bus_rdy` is low for phases 14–24.
- Display fetch with `disp_addr` 0x010, RAM[0x21]=0x41, RAM[0x20]=0x07, hres_mode 0: `char_byte` 0x41 from phase 3, `att_byte` 0x07 from phase 4, and no ISA strobes during phases 1–3.
- `bus_memr` and `bus_memw` both high for 40 cycles: no strobes and `bus_rdy` stays 1.
- `CGA_SNOW_EN` defined, hres_mode 1, write 0xEE at phase 9: the next `char_byte` (phase 18 latch) is 0xEE; the following character is from RAM.

Source files
------------

// File: rtl/cga_pkg.sv
// Shared definitions for the CGA VRAM arbiter slice: ISA access FSM states,
// the sequencer phase on which a new ISA access may never start, and a helper
// telling whether a state owns the SRAM.
package cga_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } isaState_e;

    // A start on this low phase nibble would push HOLD into a display read.
    localparam logic [3:0] ISA_START_BLOCK = 4'd14;

    function automatic logic isaOwnsRam(input isaState_e s);
        return (s == SETUP) || (s == STROBE) || (s == HOLD);
    endfunction

endpackage

// File: rtl/cga_isa_port.sv
// ISA side of the VRAM arbiter: waits for the sequencer's ISA window, runs a
// fixed SETUP/STROBE/HOLD access with registered SRAM strobes, captures read
// data and holds the bus with a ready line until the access is done.
module cga_isa_port
    import cga_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            seqPhase_i,
    input  logic                  isaOpEnable_i,
    input  logic [ADDR_WIDTH-1:0] busA_i,
    input  logic                  busMemr_i,
    input  logic                  busMemw_i,
    input  logic [7:0]            busDin_i,
    input  logic [7:0]            ramD_i,
    output logic [7:0]            busDout_o,
    output logic                  busRdy_o,
    output logic [ADDR_WIDTH-1:0] isaAddr_o,
    output logic [7:0]            isaData_o,
    output logic                  isaWrite_o,
    output logic                  isaCeL_o,
    output logic                  isaOeL_o,
    output logic                  isaWeL_o,
    output isaState_e             isaState_o
);

    isaState_e             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            data_q;
    logic                  write_q;
    logic [7:0]            busDout_q;
    logic                  ceL_q;
    logic                  oeL_q;
    logic                  weL_q;

    logic request;
    logic startGate;

    assign request   = busMemr_i ^ busMemw_i;
    assign startGate = isaOpEnable_i && (seqPhase_i != ISA_START_BLOCK);

    // Access sequencer: state, captured address/data/direction, strobes and read data all move together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            busDout_q <= '0;
            ceL_q     <= 1'b1;
            oeL_q     <= 1'b1;
            weL_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!request) begin
                        state_q <= IDLE;
                    end else if (startGate) begin
                        state_q <= SETUP;
                        addr_q  <= busA_i;
                        data_q  <= busDin_i;
                        write_q <= busMemw_i;
                        ceL_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    weL_q   <= !write_q;
                    oeL_q   <= write_q;
                end
                STROBE: begin
                    state_q <= HOLD;
                    weL_q   <= 1'b1;
                    oeL_q   <= 1'b1;
                    if (!write_q) begin
                        busDout_q <= ramD_i;
                    end
                end
                HOLD: begin
                    state_q <= DONE;
                    ceL_q   <= 1'b1;
                end
                DONE: begin
                    if (!busMemr_i && !busMemw_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ceL_q   <= 1'b1;
                    oeL_q   <= 1'b1;
                    weL_q   <= 1'b1;
                end
            endcase
        end
    end

    assign busRdy_o   = !(request && (state_q != DONE));
    assign busDout_o  = busDout_q;
    assign isaAddr_o  = addr_q;
    assign isaData_o  = data_q;
    assign isaWrite_o = write_q;
    assign isaCeL_o   = ceL_q;
    assign isaOeL_o   = oeL_q;
    assign isaWeL_o   = weL_q;
    assign isaState_o = state_q;

endmodule

// File: rtl/cga_vram_arbiter.sv
// CGA VRAM arbiter: shares one 8-bit SRAM between the ISA memory port and the
// display fetch slots produced by cga_sequencer, and latches the character and
// attribute bytes for the pixel pipeline.
// Optional feature: define CGA_SNOW_EN to model CGA "snow", where a CPU access
// completing in high-resolution mode replaces the next character byte.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4:0]            clk_seq,
    input  logic                  vram_read,
    input  logic                  vram_read_a0,
    input  logic                  vram_read_char,
    input  logic                  vram_read_att,
    input  logic                  isa_op_enable,
    input  logic                  hres_mode,
    input  logic [ADDR_WIDTH-2:0] disp_addr,
    input  logic [ADDR_WIDTH-1:0] bus_a,
    input  logic                  bus_memr,
    input  logic                  bus_memw,
    input  logic [7:0]            bus_din,
    output logic [7:0]            bus_dout,
    output logic                  bus_rdy,
    output logic [ADDR_WIDTH-1:0] ram_a,
    input  logic [7:0]            ram_d,
    output logic [7:0]            ram_q,
    output logic                  ram_ce_l,
    output logic                  ram_oe_l,
    output logic                  ram_we_l,
    output logic [7:0]            char_byte,
    output logic [7:0]            att_byte
);

    logic [ADDR_WIDTH-1:0] isaAddr;
    logic [7:0]            isaData;
    logic                  isaWrite;
    logic                  isaCeL;
    logic                  isaOeL;
    logic                  isaWeL;
    isaState_e             isaState;

    logic [ADDR_WIDTH-1:0] ramA_d;
    logic [ADDR_WIDTH-1:0] ramA_q;
    logic                  ceL;
    logic                  oeL;
    logic                  weL;
    logic [7:0]            charByte_q;
    logic [7:0]            attByte_q;
    logic [7:0]            charSrc;

    cga_isa_port #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uIsaPort (
        .clk           (clk),
        .reset_n       (reset_n),
        .seqPhase_i    (clk_seq[3:0]),
        .isaOpEnable_i (isa_op_enable),
        .busA_i        (bus_a),
        .busMemr_i     (bus_memr),
        .busMemw_i     (bus_memw),
        .busDin_i      (bus_din),
        .ramD_i        (ram_d),
        .busDout_o     (bus_dout),
        .busRdy_o      (bus_rdy),
        .isaAddr_o     (isaAddr),
        .isaData_o     (isaData),
        .isaWrite_o    (isaWrite),
        .isaCeL_o      (isaCeL),
        .isaOeL_o      (isaOeL),
        .isaWeL_o      (isaWeL),
        .isaState_o    (isaState)
    );

    // SRAM mux: a running ISA access owns the RAM, otherwise a display slot does, otherwise the address parks.
    always_comb begin
        ramA_d = ramA_q;
        ceL    = 1'b1;
        oeL    = 1'b1;
        weL    = 1'b1;
        if (!isaCeL) begin
            ramA_d = isaAddr;
            ceL    = isaCeL;
            oeL    = isaOeL;
            weL    = isaWeL;
        end else if (vram_read && reset_n) begin
            ramA_d = {disp_addr, vram_read_a0};
            ceL    = 1'b0;
            oeL    = 1'b0;
        end
    end

    // Remember the last driven address so it holds when nobody uses the RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ramA_q <= '0;
        end else begin
            ramA_q <= ramA_d;
        end
    end

    assign ram_a    = ramA_d;
    assign ram_q    = isaData;
    assign ram_ce_l = ceL;
    assign ram_oe_l = oeL;
    assign ram_we_l = weL;

`ifdef CGA_SNOW_EN
    logic       snow_q;
    logic [7:0] accessByte;
    logic       unusedBits;

    assign accessByte = isaWrite ? isaData : bus_dout;
    assign unusedBits = clk_seq[4];

    // Snow flag: armed when a hires-mode access finishes, consumed by the next character latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snow_q <= 1'b0;
        end else if ((isaState == HOLD) && hres_mode) begin
            snow_q <= 1'b1;
        end else if (vram_read_char) begin
            snow_q <= 1'b0;
        end
    end

    assign charSrc = snow_q ? accessByte : ram_d;
`else
    logic unusedBits;

    assign unusedBits = ^{clk_seq[4], hres_mode, isaWrite};
    assign charSrc    = ram_d;
`endif

    // Display latches capture the RAM byte at the end of their fetch slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            charByte_q <= '0;
            attByte_q  <= '0;
        end else begin
            if (vram_read_char) begin
                charByte_q <= charSrc;
            end
            if (vram_read_att) begin
                attByte_q <= ram_d;
            end
        end
    end

    assign char_byte = charByte_q;
    assign att_byte  = attByte_q;

    // The sequencer's start gate must keep ISA accesses clear of display slots.
    noDisplayContention : assert property (@(posedge clk) disable iff (!reset_n)
        !(vram_read && isaOwnsRam(isaState)));

endmodule
